// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with valid/ready handshakes on both sides.
// Serial bits are collected into a DATA_W-bit word. The word is presented on a
// registered parallel output. If the output slot is still occupied when a word
// completes, the block parks that word in HOLD until the consumer frees the slot.
module sipo_deser #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      clear,
    input  logic                      s_valid,
    input  logic                      s_data,
    output logic                      s_ready,
    output logic                      m_valid,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_ready,
    output logic [$clog2(DATA_W)-1:0] bit_cnt,
    output logic [CNT_W-1:0]          word_cnt
);

    localparam int unsigned       BW   = $clog2(DATA_W);
    localparam logic [BW-1:0]     LAST = BW'(DATA_W - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;

    logic                accept;
    logic                slot_free;
    logic [DATA_W-1:0]   shifted;

    // Handshake qualifiers and the shift register value that includes the incoming bit
    always_comb begin
        s_ready   = arst_n && !clear && (state_q == COLLECT);
        accept    = s_valid && s_ready;
        slot_free = !m_valid_q || m_ready;
        if (MSB_FIRST) begin
            shifted = {shift_q[DATA_W-2:0], s_data};
        end else begin
            shifted = {s_data, shift_q[DATA_W-1:1]};
        end
    end

    // Next-state logic: collect bits, hand words to the output slot, hold on backpressure
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        word_cnt_d = word_cnt_q;

        // A take empties the slot unless a load below refills it on the same edge
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (clear) begin
            m_valid_d = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
            state_d   = COLLECT;
        end else if (state_q == HOLD) begin
            if (slot_free) begin
                m_data_d   = shift_q;
                m_valid_d  = 1'b1;
                bit_cnt_d  = '0;
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = COLLECT;
            end
        end else if (accept) begin
            if (bit_cnt_q != LAST) begin
                shift_d   = shifted;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (slot_free) begin
                m_data_d   = shifted;
                m_valid_d  = 1'b1;
                bit_cnt_d  = '0;
                word_cnt_d = word_cnt_q + 1'b1;
            end else begin
                // Completed word waits in the shift register; bit_cnt stays at LAST
                shift_d = shifted;
                state_d = HOLD;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q    <= COLLECT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign bit_cnt  = bit_cnt_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: two instances share one stimulus stream.
// u_msb is MSB-first with a 16-bit word counter.
// u_lsb is LSB-first with a 2-bit counter so that counter wrap is exercised.
// The reference model treats the block as a bit accumulator that feeds a two-deep
// word queue: one output slot plus one held word.
module tb_sipo_deser;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic clear = 1'b0;
    logic s_valid = 1'b0;
    logic s_data = 1'b0;
    logic m_ready = 1'b0;

    logic          s_ready_a, m_valid_a;
    logic [DW-1:0] m_data_a;
    logic [2:0]    bit_cnt_a;
    logic [15:0]   word_cnt_a;

    logic          s_ready_b, m_valid_b;
    logic [DW-1:0] m_data_b;
    logic [2:0]    bit_cnt_b;
    logic [1:0]    word_cnt_b;

    sipo_deser #(.DATA_W(DW), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
        .clk(clk), .arst_n(arst_n), .clear(clear), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_a), .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready),
        .bit_cnt(bit_cnt_a), .word_cnt(word_cnt_a)
    );

    sipo_deser #(.DATA_W(DW), .MSB_FIRST(1'b0), .CNT_W(2)) u_lsb (
        .clk(clk), .arst_n(arst_n), .clear(clear), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready),
        .bit_cnt(bit_cnt_b), .word_cnt(word_cnt_b)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    bit          bits[$];     // partial word, in arrival order
    logic [7:0]  exp_msb[$];  // scoreboard, MSB-first interpretation
    logic [7:0]  exp_lsb[$];  // scoreboard, LSB-first interpretation
    int          pend = 0;    // words completed but not yet taken (0..2)
    int unsigned loads = 0;   // words moved into the output slot since reset

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model update for one clock edge, given the inputs that were applied at that edge
    task automatic model_edge(input logic v, input logic d, input logic mr,
                              input logic clr, input logic rn);
        bit acc;
        logic [7:0] wm, wl;
        if (!rn) begin
            bits.delete(); exp_msb.delete(); exp_lsb.delete();
            pend = 0; loads = 0;
        end else if (clr) begin
            bits.delete(); exp_msb.delete(); exp_lsb.delete();
            pend = 0;
        end else begin
            acc = v && (pend < 2);
            if (pend >= 1 && mr) begin
                pend--;
                if (pend == 1) loads++;     // the held word moves into the slot
            end
            if (acc) begin
                bits.push_back(d);
                if (bits.size() == DW) begin
                    wm = '0; wl = '0;
                    for (int i = 0; i < DW; i++) begin
                        wm[DW-1-i] = bits[i];
                        wl[i]      = bits[i];
                    end
                    exp_msb.push_back(wm);
                    exp_lsb.push_back(wl);
                    bits.delete();
                    pend++;
                    if (pend == 1) loads++;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then check the state outputs
    task automatic step(input logic v, input logic d, input logic mr,
                        input logic clr, input logic rn);
        int exp_bc;
        s_valid = v; s_data = d; m_ready = mr; clear = clr; arst_n = rn;
        @(posedge clk);
        #1;
        model_edge(v, d, mr, clr, rn);
        exp_bc = (pend == 2) ? DW - 1 : bits.size();
        chk("m_valid_msb",  32'(m_valid_a),  32'(pend >= 1));
        chk("m_valid_lsb",  32'(m_valid_b),  32'(pend >= 1));
        chk("bit_cnt_msb",  32'(bit_cnt_a),  32'(exp_bc));
        chk("bit_cnt_lsb",  32'(bit_cnt_b),  32'(exp_bc));
        chk("word_cnt_msb", 32'(word_cnt_a), loads % 65536);
        chk("word_cnt_lsb", 32'(word_cnt_b), loads % 4);
        chk("s_ready_msb",  32'(s_ready_a),  32'(rn && !clr && pend < 2));
        chk("s_ready_lsb",  32'(s_ready_b),  32'(rn && !clr && pend < 2));
        if (!rn) begin
            chk("m_data_rst_msb", 32'(m_data_a), 32'h0);
            chk("m_data_rst_lsb", 32'(m_data_b), 32'h0);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic mr);
        for (int i = DW - 1; i >= 0; i--) step(1'b1, w[i], mr, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, mr, 1'b0, 1'b1);
    endtask

    // Monitor: a word is taken at the coming edge when it is presented and accepted
    always @(negedge clk) begin
        if (m_valid_a && m_ready && arst_n && !clear) begin
            if (exp_msb.size() == 0) begin
                chk("unexpected_word", 32'(m_data_a), 32'hFFFF_FFFF);
            end else begin
                chk("m_data_msb", 32'(m_data_a), 32'(exp_msb.pop_front()));
                chk("m_data_lsb", 32'(m_data_b), 32'(exp_lsb.pop_front()));
            end
        end
    end

    initial begin
        // reset
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // A5 (palindrome), then 1,1,0,0,0,0,0,0 -> C0 MSB-first / 03 LSB-first
        send_word(8'hA5, 1'b1);
        idle(2, 1'b1);
        send_word(8'hC0, 1'b1);
        idle(2, 1'b1);

        // backpressure: 3C sits in the slot, 81 goes to HOLD, then both drain
        send_word(8'h3C, 1'b0);
        send_word(8'h81, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // partial word flushed by clear, then a clean FF
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_word(8'hFF, 1'b1);
        idle(2, 1'b1);

        // clear drops a pending word even with m_ready high
        send_word(8'h5A, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // reset mid-word and while in HOLD
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // back-to-back words with no backpressure; the 2-bit counter wraps
        for (int w = 0; w < 6; w++) send_word(8'($urandom), 1'b1);
        idle(2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 199) != 0));
        end
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
